rng_feeder: RTL and testbench

RNG_FEEDER -- requirements
Module: rng_feeder

---
 rtl/rng_feeder.sv | 80 ++++++++
 tb/tb_rng_feeder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rng_feeder.sv
// rng_feeder: packs 64-bit SHAKE256 squeeze words into 128-bit entries and queues them for the Gaussian sampler.
// Optional RNG_FEEDER_STATS_EN adds word_cnt, a wrapping count of successful pops.
module rng_feeder #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         src_valid,
  input  logic [63:0]  src_data,
  output logic         src_ready,
  input  logic         extract,
  output logic         rng_valid,
  output logic [127:0] rng,
  output logic         err_underflow
`ifdef RNG_FEEDER_STATS_EN
  ,
  output logic [31:0]  word_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {LOW, HIGH} state_t;
  state_t        r_state, w_state_nxt;
  logic          r_en;
  logic [63:0]   r_low;
  logic [127:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_full, w_xfer, w_push, w_pop;
  assign w_full        = r_cnt == (AW+1)'(DEPTH);
  // r_en keeps src_ready low until the first edge after reset release
  assign src_ready     = r_en & ~flush & (r_state == LOW | ~w_full);
  assign w_xfer        = src_valid & src_ready;
  assign w_push        = w_xfer & (r_state == HIGH);
  assign w_pop         = extract & rng_valid & ~flush;
  assign rng_valid     = r_cnt != '0;
  assign rng           = rng_valid ? r_mem[r_rd] : '0;
  always_comb begin
    w_state_nxt = flush ? LOW : w_xfer ? (r_state == LOW ? HIGH : LOW) : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOW;
    else        r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en          <= 1'b0;
      r_low         <= '0;
      r_wr          <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
      err_underflow <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (flush) begin
        r_low         <= '0;
        r_wr          <= '0;
        r_rd          <= '0;
        r_cnt         <= '0;
        err_underflow <= 1'b0;
      end else begin
        if (w_xfer && r_state == LOW) r_low <= src_data;
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop) r_rd <= r_rd + 1'b1;
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if (extract && !rng_valid) err_underflow <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {src_data, r_low};
  end
`ifdef RNG_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     word_cnt <= '0;
    else if (flush) word_cnt <= '0;
    else if (w_pop) word_cnt <= word_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_rng_feeder.sv
// tb_rng_feeder: directed scoreboard bench for rng_feeder (DEPTH=2); word_cnt checked when RNG_FEEDER_STATS_EN is defined.
module tb_rng_feeder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         src_valid = 1'b0;
  logic [63:0]  src_data = '0;
  logic         src_ready;
  logic         extract = 1'b0;
  logic         rng_valid;
  logic [127:0] rng;
  logic         err_underflow;
`ifdef RNG_FEEDER_STATS_EN
  logic [31:0]  word_cnt;
`endif
  int total = 0;
  int bad = 0;
  logic [127:0] exp_q [$];
  rng_feeder #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .extract(extract), .rng_valid(rng_valid), .rng(rng),
    .err_underflow(err_underflow)
`ifdef RNG_FEEDER_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  // scoreboard monitor: every accepted pop must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && extract && rng_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected got=%h want=none", rng);
      end else chk("pop_order", rng, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_xfer();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!src_ready && n < 50);
    if (!src_ready) chk("xfer_timeout", 128'(src_ready), 128'd1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask
  task automatic send(input logic [63:0] d);
    src_valid = 1'b1;
    src_data  = d;
    wait_xfer();
  endtask
  task automatic pair(input logic [63:0] lo, input logic [63:0] hi);
    exp_q.push_back({hi, lo});
    send(lo);
    send(hi);
  endtask
  task automatic pop();
    extract = 1'b1;
    tick();
    extract = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_src_ready", 128'(src_ready), 128'd0);
    chk("rst_rng_valid", 128'(rng_valid), 128'd0);
    chk("rst_rng", rng, 128'd0);
    chk("rst_err", 128'(err_underflow), 128'd0);
    #21 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 128'(src_ready), 128'd1);
    // first packed word: 0x2222 lands in the upper half
    exp_q.push_back({64'h2222, 64'h1111});
    send(64'h1111);
    send(64'h2222);
    chk("first_valid", 128'(rng_valid), 128'd1);
    chk("first_rng", rng, {64'h2222, 64'h1111});
    pop();
    chk("empty_after_pop", 128'(rng_valid), 128'd0);
    // fill DEPTH=2, third pair stalls on its second word
    pair(64'hA1, 64'hA2);
    pair(64'hB1, 64'hB2);
    exp_q.push_back({64'hC2, 64'hC1});
    send(64'hC1);
    src_valid = 1'b1;
    src_data  = 64'hC2;
    repeat (3) @(negedge clk);
    chk("stall_ready", 128'(src_ready), 128'd0);
    tick();
    extract = 1'b1;
    @(negedge clk);
    chk("stall_ready_pop", 128'(src_ready), 128'd0);
    tick();
    extract = 1'b0;
    wait_xfer();
    pop();
    pop();
    chk("drained", 128'(rng_valid), 128'd0);
    // underflow is sticky and only flush clears it
    pop();
    chk("uf_err", 128'(err_underflow), 128'd1);
    chk("uf_valid", 128'(rng_valid), 128'd0);
    chk("uf_rng", rng, 128'd0);
    tick();
    tick();
    chk("uf_sticky", 128'(err_underflow), 128'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("uf_flushed", 128'(err_underflow), 128'd0);
    // simultaneous push and pop with one entry queued
    pair(64'hD1, 64'hD2);
    exp_q.push_back({64'hE2, 64'hE1});
    send(64'hE1);
    src_valid = 1'b1;
    src_data  = 64'hE2;
    extract   = 1'b1;
    wait_xfer();
    extract = 1'b0;
    chk("pp_valid", 128'(rng_valid), 128'd1);
    chk("pp_rng", rng, {64'hE2, 64'hE1});
    pop();
    chk("pp_count1", 128'(rng_valid), 128'd0);
    // reset mid-packet drops the held low word
    send(64'hF1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(src_ready), 128'd0);
    #2 rst_n = 1'b1;
    tick();
    pair(64'h61, 64'h62);
    chk("midrst_rng", rng, {64'h62, 64'h61});
    pop();
    // flush beats an offered word
    send(64'h71);
    src_valid = 1'b1;
    src_data  = 64'h99;
    flush     = 1'b1;
    @(negedge clk);
    chk("flush_ready", 128'(src_ready), 128'd0);
    tick();
    flush     = 1'b0;
    src_valid = 1'b0;
    pair(64'h81, 64'h82);
    chk("flush_pack", rng, {64'h82, 64'h81});
    pop();
    // extract held: pops once per cycle, then underflows
    pair(64'h91, 64'h92);
    pair(64'hB3, 64'hB4);
    extract = 1'b1;
    repeat (3) tick();
    extract = 1'b0;
    chk("held_err", 128'(err_underflow), 128'd1);
    chk("held_empty", 128'(rng_valid), 128'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    // five good pops plus one underflow
    for (int i = 0; i < 5; i++) begin
      pair(64'(i * 2 + 1), 64'(i * 2 + 2));
      pop();
    end
    pop();
    chk("stats_err", 128'(err_underflow), 128'd1);
`ifdef RNG_FEEDER_STATS_EN
    chk("word_cnt", 128'(word_cnt), 128'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("word_cnt_flush", 128'(word_cnt), 128'd0);
`endif
    chk("queue_left", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
